// File: rtl/sequencer_supervisor_if.sv
// Bus between the sequencer supervisor and the system/rail chain.
// The master modport is the supervisor side; slave is the system/rail side.
interface sequencer_supervisor_if #(
  parameter int NUM_RAILS = 4,
  parameter int MAX_RETRY = 3
);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  // Every signal is a level sampled on each CLOCK edge; there is no valid/ready
  // pairing, and supervisor outputs are registered, moving one cycle after their cause.
  logic                 PWR_REQ;
  logic                 FAULT_CLR;
  logic [NUM_RAILS-1:0] RAIL_FAULT;
  logic [NUM_RAILS-1:0] RAIL_DCHG;
  logic                 LAST_OE;
  logic                 SEQ_ENABLE;
  logic                 SEQ_KEEPALIVE;
  logic                 PWR_GOOD;
  logic                 FAULT_LOCK;
  logic [NUM_RAILS-1:0] FAULT_RAIL;
  logic [RETRY_W-1:0]   RETRY_CNT;

  modport master (
    input  PWR_REQ, FAULT_CLR, RAIL_FAULT, RAIL_DCHG, LAST_OE,
    output SEQ_ENABLE, SEQ_KEEPALIVE, PWR_GOOD, FAULT_LOCK, FAULT_RAIL, RETRY_CNT
  );

  modport slave (
    output PWR_REQ, FAULT_CLR, RAIL_FAULT, RAIL_DCHG, LAST_OE,
    input  SEQ_ENABLE, SEQ_KEEPALIVE, PWR_GOOD, FAULT_LOCK, FAULT_RAIL, RETRY_CNT
  );
endinterface

// File: rtl/sequencer_supervisor.sv
// Power-rail chain supervisor: sequences up/down, times out, retries, locks out.
// Define SEQ_AUTO_RETRY_EN to enable the hold-off/retry path; otherwise any fault locks out.
module sequencer_supervisor #(
  parameter int NUM_RAILS   = 4,
  parameter int DLY_PUP_TMO = 200,
  parameter int DLY_PDN_TMO = 400,
  parameter int DLY_RETRY   = 100,
  parameter int MAX_RETRY   = 3,
  parameter int C_CNTRSIZE  = 16
) (
  input  logic                   CLOCK,
  input  logic                   RESET_N,
  sequencer_supervisor_if.master bus,
  output logic [2:0]             dbg_state
);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_PWRUP   = 3'd1,
    ST_ON      = 3'd2,
    ST_PWRDN   = 3'd3,
    ST_HOLDOFF = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [C_CNTRSIZE-1:0] timer_q, timer_d, tmo_lim;
  logic                  fault_flag_q, fault_flag_d;
  logic [NUM_RAILS-1:0]  fault_rail_q, fault_rail_d;
  logic [RETRY_W-1:0]    retry_q, retry_d;
  logic                  seq_enable_q, seq_enable_d;
  logic                  keepalive_q, keepalive_d;
  logic                  pwr_good_q, pwr_good_d;
  logic                  fault_lock_q, fault_lock_d;
  logic                  any_fault, all_dchg, tmo_hit, retry_ok, fault_evt;

  assign any_fault = |bus.RAIL_FAULT;
  assign all_dchg  = &bus.RAIL_DCHG;
  assign tmo_hit   = (timer_q >= tmo_lim);

`ifdef SEQ_AUTO_RETRY_EN
  assign retry_ok  = (retry_q < RETRY_W'(MAX_RETRY));
`else
  assign retry_ok  = 1'b0;
`endif

  // One shared timer; its limit depends on which state is being timed.
  always_comb begin
    tmo_lim = {C_CNTRSIZE{1'b1}};
    case (state_q)
      ST_PWRUP:   tmo_lim = C_CNTRSIZE'(DLY_PUP_TMO);
      ST_PWRDN:   tmo_lim = C_CNTRSIZE'(DLY_PDN_TMO);
      ST_HOLDOFF: tmo_lim = C_CNTRSIZE'(DLY_RETRY);
      default:    ;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_OFF;
      timer_q      <= '0;
      fault_flag_q <= 1'b0;
      fault_rail_q <= '0;
      retry_q      <= '0;
      seq_enable_q <= 1'b0;
      keepalive_q  <= 1'b0;
      pwr_good_q   <= 1'b0;
      fault_lock_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      fault_flag_q <= fault_flag_d;
      fault_rail_q <= fault_rail_d;
      retry_q      <= retry_d;
      seq_enable_q <= seq_enable_d;
      keepalive_q  <= keepalive_d;
      pwr_good_q   <= pwr_good_d;
      fault_lock_q <= fault_lock_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fault_flag_d = fault_flag_q;
    fault_rail_d = fault_rail_q;
    retry_d      = retry_q;
    fault_evt    = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (bus.PWR_REQ && !fault_lock_q && all_dchg) state_d = ST_PWRUP;
      end
      ST_PWRUP: begin
        if (any_fault)         fault_evt = 1'b1;
        else if (!bus.PWR_REQ) state_d   = ST_PWRDN;
        else if (bus.LAST_OE)  state_d   = ST_ON;
        else if (tmo_hit)      fault_evt = 1'b1;
      end
      ST_ON: begin
        if (any_fault || !bus.LAST_OE) fault_evt = 1'b1;
        else if (!bus.PWR_REQ)         state_d   = ST_PWRDN;
      end
      ST_PWRDN: begin
        if (all_dchg) begin
          if (fault_flag_q) state_d = retry_ok ? ST_HOLDOFF : ST_LOCKOUT;
          else              state_d = ST_OFF;
        end else if (tmo_hit) begin
          state_d = ST_LOCKOUT;
        end
      end
`ifdef SEQ_AUTO_RETRY_EN
      ST_HOLDOFF: begin
        if (tmo_hit) begin
          retry_d      = retry_q + RETRY_W'(1);
          fault_flag_d = 1'b0;
          state_d      = bus.PWR_REQ ? ST_PWRUP : ST_OFF;
        end
      end
`endif
      ST_LOCKOUT: begin
        if (bus.FAULT_CLR && !bus.PWR_REQ) begin
          state_d      = ST_OFF;
          fault_rail_d = '0;
          retry_d      = '0;
          fault_flag_d = 1'b0;
        end
      end
      default: state_d = ST_OFF;
    endcase

    // A fault overrides any transition chosen above and starts discharge at once.
    if (fault_evt) begin
      fault_rail_d = fault_rail_q | bus.RAIL_FAULT;
      fault_flag_d = 1'b1;
      state_d      = ST_PWRDN;
    end
    if (state_d == ST_ON && state_q != ST_ON) retry_d = '0;
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    if (state_d != state_q) timer_d = '0;
    else if (&timer_q)      timer_d = timer_q;
    else                    timer_d = timer_q + C_CNTRSIZE'(1);
    seq_enable_d = (state_d == ST_PWRUP) || (state_d == ST_ON);
    pwr_good_d   = (state_d == ST_ON);
    keepalive_d  = (state_d == ST_ON) && bus.PWR_REQ && !any_fault;
    fault_lock_d = (state_d == ST_LOCKOUT);
  end

  assign bus.SEQ_ENABLE    = seq_enable_q;
  assign bus.SEQ_KEEPALIVE = keepalive_q;
  assign bus.PWR_GOOD      = pwr_good_q;
  assign bus.FAULT_LOCK    = fault_lock_q;
  assign bus.FAULT_RAIL    = fault_rail_q;
`ifdef SEQ_AUTO_RETRY_EN
  assign bus.RETRY_CNT     = retry_q;
`else
  assign bus.RETRY_CNT     = '0;
`endif
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_sequencer_supervisor.sv
// Directed bench for sequencer_supervisor; expectations follow the build's retry macro.
module tb_sequencer_supervisor;
  localparam logic [2:0] S_OFF = 3'd0, S_PWRUP = 3'd1, S_ON = 3'd2,
                         S_PWRDN = 3'd3, S_HOLDOFF = 3'd4, S_LOCKOUT = 3'd5;
`ifdef SEQ_AUTO_RETRY_EN
  localparam int         EXP_RETRIES  = 3;
  localparam logic [2:0] EXP_FAULT_ST = S_HOLDOFF;
`else
  localparam int         EXP_RETRIES  = 0;
  localparam logic [2:0] EXP_FAULT_ST = S_LOCKOUT;
`endif

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;
  int         checks;
  int         errors;

  sequencer_supervisor_if #(.NUM_RAILS(4), .MAX_RETRY(3)) bus ();

  sequencer_supervisor #(
    .NUM_RAILS(4), .DLY_PUP_TMO(200), .DLY_PDN_TMO(400),
    .DLY_RETRY(100), .MAX_RETRY(3), .C_CNTRSIZE(16)
  ) dut (
    .CLOCK     (clk),
    .RESET_N   (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // {SEQ_ENABLE, SEQ_KEEPALIVE, PWR_GOOD, FAULT_LOCK}
  wire [3:0] flags = {bus.SEQ_ENABLE, bus.SEQ_KEEPALIVE, bus.PWR_GOOD, bus.FAULT_LOCK};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic req, input logic clr, input logic [3:0] flt,
                        input logic [3:0] dchg, input logic oe);
    bus.PWR_REQ    = req;
    bus.FAULT_CLR  = clr;
    bus.RAIL_FAULT = flt;
    bus.RAIL_DCHG  = dchg;
    bus.LAST_OE    = oe;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 4'h0, 4'hF, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic go_on();
    apply_reset();
    set_in(1'b1, 1'b0, 4'h0, 4'hF, 1'b1);
    tick(2);
    bus.RAIL_DCHG = 4'h0;
    checks++;
    if (dbg_state !== S_ON || flags !== 4'b1110) begin
      errors++;
      $display("FAIL go_on: state=%0d flags=%b want state=%0d flags=1110", dbg_state, flags, S_ON);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1'b1, 1'b0, 4'h0, 4'hF, 1'b1);
    tick(2);
    checks++;
    if (dbg_state !== S_OFF) begin
      errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_OFF);
    end
    checks++;
    if (flags !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", flags);
    end
    checks++;
    if (bus.FAULT_RAIL !== 4'h0 || bus.RETRY_CNT !== 2'd0) begin
      errors++; $display("FAIL reset_rail_retry: got %b/%0d want 0000/0", bus.FAULT_RAIL, bus.RETRY_CNT);
    end
    rst_n = 1'b1;
    bus.PWR_REQ = 1'b0;
    tick(1);
  endtask

  task automatic test_power_up();
    apply_reset();
    set_in(1'b1, 1'b0, 4'h0, 4'b1110, 1'b0);
    tick(3);
    checks++;
    if (dbg_state !== S_OFF || flags !== 4'b0000) begin
      errors++; $display("FAIL pup_wait_dchg: state=%0d flags=%b want 0/0000", dbg_state, flags);
    end
    bus.RAIL_DCHG = 4'hF;
    tick(1);
    checks++;
    if (dbg_state !== S_PWRUP || flags !== 4'b1000) begin
      errors++; $display("FAIL pup_enter: state=%0d flags=%b want 1/1000", dbg_state, flags);
    end
    tick(49);
    bus.LAST_OE   = 1'b1;
    bus.RAIL_DCHG = 4'h0;
    checks++;
    if (flags !== 4'b1000) begin
      errors++; $display("FAIL pup_before_oe: flags=%b want 1000", flags);
    end
    tick(1);
    checks++;
    if (dbg_state !== S_ON || flags !== 4'b1110 || bus.RETRY_CNT !== 2'd0) begin
      errors++;
      $display("FAIL pup_good: state=%0d flags=%b retry=%0d want 2/1110/0", dbg_state, flags, bus.RETRY_CNT);
    end
    tick(5);
    bus.PWR_REQ = 1'b0;
    tick(1);
    checks++;
    if (dbg_state !== S_PWRDN || flags !== 4'b0000 || bus.FAULT_RAIL !== 4'h0) begin
      errors++;
      $display("FAIL clean_pdn: state=%0d flags=%b rail=%b want 3/0000/0000", dbg_state, flags, bus.FAULT_RAIL);
    end
    bus.LAST_OE = 1'b0;
    tick(5);
    bus.RAIL_DCHG = 4'hF;
    tick(1);
    checks++;
    if (dbg_state !== S_OFF || flags !== 4'b0000) begin
      errors++; $display("FAIL clean_off: state=%0d flags=%b want 0/0000", dbg_state, flags);
    end
  endtask

  task automatic test_rail_fault();
    go_on();
    bus.RAIL_FAULT = 4'b0100;
    tick(1);
    checks++;
    if (dbg_state !== S_PWRDN || flags !== 4'b0000 || bus.FAULT_RAIL !== 4'b0100) begin
      errors++;
      $display("FAIL fault_pdn: state=%0d flags=%b rail=%b want 3/0000/0100", dbg_state, flags, bus.FAULT_RAIL);
    end
    bus.RAIL_FAULT = 4'h0;
    tick(10);
    bus.RAIL_DCHG = 4'hF;
    tick(1);
    checks++;
    if (dbg_state !== EXP_FAULT_ST || bus.RETRY_CNT !== 2'd0) begin
      errors++;
      $display("FAIL fault_after_dchg: state=%0d retry=%0d want %0d/0", dbg_state, bus.RETRY_CNT, EXP_FAULT_ST);
    end
`ifdef SEQ_AUTO_RETRY_EN
    tick(100);
    checks++;
    if (dbg_state !== S_HOLDOFF || bus.RETRY_CNT !== 2'd0) begin
      errors++; $display("FAIL holdoff_hold: state=%0d retry=%0d want 4/0", dbg_state, bus.RETRY_CNT);
    end
    tick(1);
    checks++;
    if (dbg_state !== S_PWRUP || bus.RETRY_CNT !== 2'd1 || flags !== 4'b1000 || bus.FAULT_RAIL !== 4'b0100) begin
      errors++;
      $display("FAIL retry_1: state=%0d retry=%0d flags=%b rail=%b want 1/1/1000/0100",
               dbg_state, bus.RETRY_CNT, flags, bus.FAULT_RAIL);
    end
    tick(1);
    checks++;
    if (dbg_state !== S_ON || bus.RETRY_CNT !== 2'd0) begin
      errors++; $display("FAIL retry_on_clear: state=%0d retry=%0d want 2/0", dbg_state, bus.RETRY_CNT);
    end
`else
    checks++;
    if (flags !== 4'b0001 || bus.FAULT_RAIL !== 4'b0100) begin
      errors++; $display("FAIL lock_flags: flags=%b rail=%b want 0001/0100", flags, bus.FAULT_RAIL);
    end
    set_in(1'b0, 1'b1, 4'h0, 4'hF, 1'b0);
    tick(1);
    checks++;
    if (dbg_state !== S_OFF || flags !== 4'b0000 || bus.FAULT_RAIL !== 4'h0) begin
      errors++;
      $display("FAIL lock_clear: state=%0d flags=%b rail=%b want 0/0000/0000", dbg_state, flags, bus.FAULT_RAIL);
    end
`endif
  endtask

  task automatic test_pup_timeout();
    apply_reset();
    set_in(1'b1, 1'b0, 4'h0, 4'hF, 1'b0);
    tick(1);
    for (int r = 0; r <= EXP_RETRIES; r++) begin
      tick(200);
      checks++;
      if (dbg_state !== S_PWRUP) begin
        errors++; $display("FAIL tmo_edge_%0d: state=%0d want 1", r, dbg_state);
      end
      tick(1);
      checks++;
      if (dbg_state !== S_PWRDN || flags !== 4'b0000) begin
        errors++; $display("FAIL tmo_pdn_%0d: state=%0d flags=%b want 3/0000", r, dbg_state, flags);
      end
      tick(1);
      if (r < EXP_RETRIES) begin
        checks++;
        if (dbg_state !== S_HOLDOFF || bus.RETRY_CNT !== 2'(r)) begin
          errors++; $display("FAIL tmo_hold_%0d: state=%0d retry=%0d want 4/%0d", r, dbg_state, bus.RETRY_CNT, r);
        end
        tick(101);
        checks++;
        if (dbg_state !== S_PWRUP || bus.RETRY_CNT !== 2'(r + 1) || flags !== 4'b1000) begin
          errors++;
          $display("FAIL tmo_retry_%0d: state=%0d retry=%0d flags=%b want 1/%0d/1000",
                   r, dbg_state, bus.RETRY_CNT, flags, r + 1);
        end
      end else begin
        checks++;
        if (dbg_state !== S_LOCKOUT || flags !== 4'b0001 || bus.RETRY_CNT !== 2'(r)) begin
          errors++;
          $display("FAIL tmo_lock: state=%0d flags=%b retry=%0d want 5/0001/%0d", dbg_state, flags, bus.RETRY_CNT, r);
        end
      end
    end
    bus.FAULT_CLR = 1'b1;
    tick(2);
    checks++;
    if (dbg_state !== S_LOCKOUT || flags !== 4'b0001) begin
      errors++; $display("FAIL clr_needs_req_low: state=%0d flags=%b want 5/0001", dbg_state, flags);
    end
    bus.PWR_REQ = 1'b0;
    tick(1);
    checks++;
    if (dbg_state !== S_OFF || flags !== 4'b0000 || bus.FAULT_RAIL !== 4'h0 || bus.RETRY_CNT !== 2'd0) begin
      errors++;
      $display("FAIL clr_all: state=%0d flags=%b rail=%b retry=%0d want 0/0000/0000/0",
               dbg_state, flags, bus.FAULT_RAIL, bus.RETRY_CNT);
    end
  endtask

  task automatic test_dchg_stuck();
    go_on();
    bus.PWR_REQ = 1'b0;
    tick(1);
    tick(400);
    checks++;
    if (dbg_state !== S_PWRDN || flags !== 4'b0000) begin
      errors++; $display("FAIL stuck_wait: state=%0d flags=%b want 3/0000", dbg_state, flags);
    end
    tick(1);
    checks++;
    if (dbg_state !== S_LOCKOUT || flags !== 4'b0001 || bus.FAULT_RAIL !== 4'h0) begin
      errors++;
      $display("FAIL stuck_lock: state=%0d flags=%b rail=%b want 5/0001/0000", dbg_state, flags, bus.FAULT_RAIL);
    end
  endtask

  task automatic test_fault_and_req_fall();
    go_on();
    bus.RAIL_FAULT = 4'b0001;
    bus.PWR_REQ    = 1'b0;
    tick(1);
    checks++;
    if (dbg_state !== S_PWRDN || bus.FAULT_RAIL !== 4'b0001 || flags !== 4'b0000) begin
      errors++;
      $display("FAIL same_cycle_pdn: state=%0d rail=%b flags=%b want 3/0001/0000", dbg_state, bus.FAULT_RAIL, flags);
    end
    bus.RAIL_FAULT = 4'h0;
    bus.RAIL_DCHG  = 4'hF;
    tick(1);
    checks++;
    if (dbg_state !== EXP_FAULT_ST) begin
      errors++; $display("FAIL same_cycle_path: state=%0d want %0d", dbg_state, EXP_FAULT_ST);
    end
`ifdef SEQ_AUTO_RETRY_EN
    tick(101);
    checks++;
    if (dbg_state !== S_OFF || bus.RETRY_CNT !== 2'd1) begin
      errors++; $display("FAIL holdoff_to_off: state=%0d retry=%0d want 0/1", dbg_state, bus.RETRY_CNT);
    end
`endif
    go_on();
    bus.LAST_OE = 1'b0;
    tick(1);
    checks++;
    if (dbg_state !== S_PWRDN || bus.FAULT_RAIL !== 4'h0) begin
      errors++; $display("FAIL oe_drop_pdn: state=%0d rail=%b want 3/0000", dbg_state, bus.FAULT_RAIL);
    end
    bus.RAIL_DCHG = 4'hF;
    tick(1);
    checks++;
    if (dbg_state !== EXP_FAULT_ST) begin
      errors++; $display("FAIL oe_drop_path: state=%0d want %0d", dbg_state, EXP_FAULT_ST);
    end
  endtask

  task automatic test_async_reset();
    go_on();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (flags !== 4'b0000 || dbg_state !== S_OFF || bus.FAULT_RAIL !== 4'h0) begin
      errors++;
      $display("FAIL async_reset: state=%0d flags=%b rail=%b want 0/0000/0000", dbg_state, flags, bus.FAULT_RAIL);
    end
    tick(1);
    bus.RAIL_DCHG = 4'hF;
    rst_n = 1'b1;
    tick(1);
    checks++;
    if (dbg_state !== S_PWRUP || flags !== 4'b1000) begin
      errors++; $display("FAIL restart_after_reset: state=%0d flags=%b want 1/1000", dbg_state, flags);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    set_in(1'b0, 1'b0, 4'h0, 4'hF, 1'b0);
    test_reset();
    test_power_up();
    test_rail_fault();
    test_pup_timeout();
    test_dchg_stuck();
    test_fault_and_req_fall();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
